// File: rtl/ras_ckpt_pkg.sv
// Shared definitions for the checkpointed return-address stack.
// The predictor op encoding and the checkpoint count from the core configuration.
package ras_ckpt_pkg;

    typedef enum logic [1:0] {
        RAS_NONE    = 2'b00,
        RAS_PUSH    = 2'b01,
        RAS_POP     = 2'b10,
        RAS_PUSHPOP = 2'b11
    } ras_op_e;

    localparam int CFG_RAS_DEPTH = 2;
    localparam int RAS_NR_CKPT   = 4;

endpackage

// File: rtl/ras_ckpt_alloc.sv
// Circular checkpoint allocator: head/tail/occupancy with save, release and restore-truncate.
// State changes on the next edge; a save while full is dropped unless a release lands in the same cycle.
module ras_ckpt_alloc #(
    parameter int NR = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  save_i,
    input  logic                  release_i,
    input  logic                  restore_i,
    input  logic [$clog2(NR)-1:0] restore_id_i,
    output logic [$clog2(NR)-1:0] head_o,
    output logic                  full_o,
    output logic                  save_ok_o
);
    localparam int IW = $clog2(NR);
    localparam int OW = IW + 1;

    logic [IW-1:0] r_head, r_tail;
    logic [OW-1:0] r_occ;
    logic          r_full;

    logic [IW-1:0] w_head_n, w_tail_n, w_diff;
    logic [OW-1:0] w_occ_n;
    logic          w_rel;

    assign w_rel     = release_i && !flush_i && (r_occ != '0);
    assign save_ok_o = save_i && !flush_i && !restore_i && ((r_occ != OW'(NR)) || w_rel);
    assign w_tail_n  = r_tail + IW'(w_rel);
    assign w_diff    = restore_id_i - w_tail_n;

    always_comb begin
        w_head_n = r_head;
        w_occ_n  = r_occ;
        if (flush_i) begin
            w_head_n = '0;
            w_occ_n  = '0;
        end else if (restore_i) begin
            // Release is applied first, so truncation is measured from the new tail.
            w_head_n = restore_id_i;
            w_occ_n  = {1'b0, w_diff};
        end else begin
            w_head_n = r_head + IW'(save_ok_o);
            w_occ_n  = r_occ + OW'(save_ok_o) - OW'(w_rel);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_full <= 1'b0;
        end else begin
            r_head <= w_head_n;
            r_tail <= flush_i ? '0 : w_tail_n;
            r_occ  <= w_occ_n;
            r_full <= (w_occ_n == OW'(NR));
        end
    end

    assign head_o = r_head;
    assign full_o = r_full;

    logic [IW-1:0] w_dist;
    assign w_dist = restore_id_i - r_tail;

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (restore_i && !flush_i) |-> ({1'b0, w_dist} < r_occ));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (restore_i && !flush_i && release_i) |-> (restore_id_i != r_tail));

endmodule

// File: rtl/ras_ckpt.sv
// Circular return-address stack with speculative checkpoints for misprediction rollback.
// Outputs reflect state one cycle after a request; no input-to-output path, no backpressure.
module ras_ckpt
    import ras_ckpt_pkg::*;
#(
    parameter int DEPTH   = CFG_RAS_DEPTH,
    parameter int VLEN    = 32,
    parameter int NR_CKPT = RAS_NR_CKPT
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [VLEN-1:0]            data_i,
    output logic [VLEN-1:0]            data_o,
    output logic                       valid_o,
    input  logic                       ckpt_save_i,
    output logic [$clog2(NR_CKPT)-1:0] ckpt_id_o,
    output logic                       ckpt_full_o,
    input  logic                       ckpt_restore_i,
    input  logic [$clog2(NR_CKPT)-1:0] ckpt_restore_id_i,
    input  logic                       ckpt_release_i
);
    localparam int TW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TW-1:0]   tos;
        logic [CW-1:0]   cnt;
        logic [VLEN-1:0] top;
    } ckpt_t;

    logic [VLEN-1:0] r_stack [DEPTH];
    ckpt_t           r_ckpt  [NR_CKPT];
    logic [TW-1:0]   r_tos;
    logic [CW-1:0]   r_cnt;

    ras_op_e         w_op;
    ckpt_t           w_rst_rec, w_save_rec;
    logic [TW-1:0]   w_tos_inc, w_tos_dec, w_tos_n, w_wr_idx;
    logic [CW-1:0]   w_cnt_n;
    logic [VLEN-1:0] w_wr_dat;
    logic            w_wr_en, w_save_ok;
    logic [$clog2(NR_CKPT)-1:0] w_head;

    assign w_op      = ras_op_e'({pop_i, push_i});
    assign w_tos_inc = (r_tos == TW'(DEPTH - 1)) ? '0 : r_tos + 1'b1;
    assign w_tos_dec = (r_tos == '0) ? TW'(DEPTH - 1) : r_tos - 1'b1;
    assign w_rst_rec = r_ckpt[ckpt_restore_id_i];

    always_comb begin
        w_tos_n  = r_tos;
        w_cnt_n  = r_cnt;
        w_wr_en  = 1'b0;
        w_wr_idx = r_tos;
        w_wr_dat = data_i;
        if (flush_i) begin
            w_tos_n = '0;
            w_cnt_n = '0;
        end else if (ckpt_restore_i) begin
            // Rewrite the saved top: wrong-path pushes may have clobbered that slot.
            w_tos_n  = w_rst_rec.tos;
            w_cnt_n  = w_rst_rec.cnt;
            w_wr_en  = 1'b1;
            w_wr_idx = w_rst_rec.tos;
            w_wr_dat = w_rst_rec.top;
        end else begin
            case (w_op)
                RAS_PUSH: begin
                    w_tos_n  = w_tos_inc;
                    w_cnt_n  = (r_cnt == CW'(DEPTH)) ? r_cnt : r_cnt + 1'b1;
                    w_wr_en  = 1'b1;
                    w_wr_idx = w_tos_inc;
                end
                RAS_POP: begin
                    if (r_cnt != '0) begin
                        w_tos_n = w_tos_dec;
                        w_cnt_n = r_cnt - 1'b1;
                    end
                end
                RAS_PUSHPOP: begin
                    w_cnt_n = (r_cnt == '0) ? CW'(1) : r_cnt;
                    w_wr_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_save_rec.tos = w_tos_n;
        w_save_rec.cnt = w_cnt_n;
        w_save_rec.top = w_wr_en ? w_wr_dat : r_stack[w_tos_n];
    end

    ras_ckpt_alloc #(.NR(NR_CKPT)) u_alloc (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .save_i       (ckpt_save_i),
        .release_i    (ckpt_release_i),
        .restore_i    (ckpt_restore_i),
        .restore_id_i (ckpt_restore_id_i),
        .head_o       (w_head),
        .full_o       (ckpt_full_o),
        .save_ok_o    (w_save_ok)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tos <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
            for (int j = 0; j < NR_CKPT; j++) r_ckpt[j] <= '0;
        end else begin
            r_tos <= w_tos_n;
            r_cnt <= w_cnt_n;
            if (w_wr_en) r_stack[w_wr_idx] <= w_wr_dat;
            if (w_save_ok) r_ckpt[w_head] <= w_save_rec;
        end
    end

    assign data_o    = r_stack[r_tos];
    assign valid_o   = (r_cnt != '0);
    assign ckpt_id_o = w_head;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: one DEPTH=2 and one DEPTH=3 instance share all stimulus.
module tb_ras_ckpt;
    logic        clk, rst_n, flush, push, pop, save, rest, rel;
    logic [31:0] din;
    logic [1:0]  rid;
    logic [31:0] d2, d3;
    logic        v2, v3, f2, f3;
    logic [1:0]  id2, id3;
    int          total = 0;
    int          bad = 0;

    ras_ckpt #(.DEPTH(2), .VLEN(32), .NR_CKPT(4)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(din), .data_o(d2), .valid_o(v2), .ckpt_save_i(save), .ckpt_id_o(id2),
        .ckpt_full_o(f2), .ckpt_restore_i(rest), .ckpt_restore_id_i(rid),
        .ckpt_release_i(rel)
    );

    ras_ckpt #(.DEPTH(3), .VLEN(32), .NR_CKPT(4)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(din), .data_o(d3), .valid_o(v3), .ckpt_save_i(save), .ckpt_id_o(id3),
        .ckpt_full_o(f3), .ckpt_restore_i(rest), .ckpt_restore_id_i(rid),
        .ckpt_release_i(rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic pu, input logic po, input logic [31:0] d,
                       input logic sv, input logic rs, input logic [1:0] k,
                       input logic rl, input logic fl);
        push = pu; pop = po; din = d; save = sv; rest = rs; rid = k; rel = rl; flush = fl;
        @(posedge clk);
        #1;
        push = 0; pop = 0; din = '0; save = 0; rest = 0; rid = '0; rel = 0; flush = 0;
    endtask

    task automatic do_flush();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        total++; if (d2 !== 32'h0) begin bad++; $display("FAIL reset_data2 got=%h want=%h", d2, 32'h0); end
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL reset_valid2 got=%b want=0", v2); end
        total++; if (id2 !== 2'd0) begin bad++; $display("FAIL reset_id2 got=%0d want=0", id2); end
        total++; if (f2 !== 1'b0) begin bad++; $display("FAIL reset_full2 got=%b want=0", f2); end
        total++; if (d3 !== 32'h0 || v3 !== 1'b0) begin bad++; $display("FAIL reset_u3 got=%h/%b want=0/0", d3, v3); end
    endtask

    task automatic test_basic();
        cyc(1, 0, 32'h100, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'h200, 0, 0, 0, 0, 0);
        total++; if (d2 !== 32'h200 || v2 !== 1'b1) begin bad++; $display("FAIL basic_push got=%h/%b want=200/1", d2, v2); end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (d2 !== 32'h100 || v2 !== 1'b1) begin bad++; $display("FAIL basic_pop1 got=%h/%b want=100/1", d2, v2); end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL basic_pop2_valid got=%b want=0", v2); end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL underflow_valid got=%b want=0", v2); end
        total++; if (d2 !== 32'h200) begin bad++; $display("FAIL underflow_tos got=%h want=%h", d2, 32'h200); end
        do_flush();
    endtask

    task automatic test_overflow();
        cyc(1, 0, 32'hA, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'hB, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'hC, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'hD, 0, 0, 0, 0, 0);
        total++; if (d3 !== 32'hD || v3 !== 1'b1) begin bad++; $display("FAIL ovf_top got=%h/%b want=d/1", d3, v3); end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (d3 !== 32'hC || v3 !== 1'b1) begin bad++; $display("FAIL ovf_pop1 got=%h/%b want=c/1", d3, v3); end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (d3 !== 32'hB || v3 !== 1'b1) begin bad++; $display("FAIL ovf_pop2 got=%h/%b want=b/1", d3, v3); end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (v3 !== 1'b0) begin bad++; $display("FAIL ovf_pop3_valid got=%b want=0", v3); end
        do_flush();
    endtask

    task automatic test_pushpop();
        cyc(1, 0, 32'h10, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h20, 0, 0, 0, 0, 0);
        total++; if (d2 !== 32'h20 || v2 !== 1'b1) begin bad++; $display("FAIL pp_top got=%h/%b want=20/1", d2, v2); end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL pp_count1 got=%b want=0", v2); end
        cyc(1, 1, 32'h30, 0, 0, 0, 0, 0);
        total++; if (d2 !== 32'h30 || v2 !== 1'b1) begin bad++; $display("FAIL pp_empty got=%h/%b want=30/1", d2, v2); end
        do_flush();
    endtask

    task automatic test_restore();
        cyc(1, 0, 32'h40, 1, 0, 0, 0, 0);
        total++; if (id2 !== 2'd1) begin bad++; $display("FAIL rst_save_id got=%0d want=1", id2); end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'h50, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'h60, 0, 0, 0, 0, 0);
        total++; if (d2 !== 32'h60) begin bad++; $display("FAIL rst_wrongpath got=%h want=60", d2); end
        cyc(1, 0, 32'h77, 1, 1, 2'd0, 0, 0);
        total++; if (d2 !== 32'h40 || v2 !== 1'b1) begin bad++; $display("FAIL rst_data got=%h/%b want=40/1", d2, v2); end
        total++; if (id2 !== 2'd0) begin bad++; $display("FAIL rst_head got=%0d want=0", id2); end
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL rst_count got=%b want=0", v2); end
        do_flush();
    endtask

    task automatic test_full();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0);
        total++; if (f2 !== 1'b0 || id2 !== 2'd3) begin bad++; $display("FAIL full_three got=%b/%0d want=0/3", f2, id2); end
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        total++; if (f2 !== 1'b1 || id2 !== 2'd0) begin bad++; $display("FAIL full_four got=%b/%0d want=1/0", f2, id2); end
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        total++; if (f2 !== 1'b1 || id2 !== 2'd0) begin bad++; $display("FAIL full_fifth got=%b/%0d want=1/0", f2, id2); end
        cyc(0, 0, 0, 1, 0, 0, 1, 0);
        total++; if (f2 !== 1'b1 || id2 !== 2'd1) begin bad++; $display("FAIL full_relsave got=%b/%0d want=1/1", f2, id2); end
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        total++; if (f3 !== 1'b0 || id3 !== 2'd1) begin bad++; $display("FAIL full_release got=%b/%0d want=0/1", f3, id3); end
        do_flush();
    endtask

    task automatic test_truncate();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 2'd1, 0, 0);
        total++; if (id2 !== 2'd1 || f2 !== 1'b0) begin bad++; $display("FAIL trunc_head got=%0d/%b want=1/0", id2, f2); end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0);
        total++; if (f2 !== 1'b1 || id2 !== 2'd0) begin bad++; $display("FAIL trunc_refill got=%b/%0d want=1/0", f2, id2); end
    endtask

    task automatic test_flush();
        cyc(1, 0, 32'h11, 0, 0, 0, 0, 0);
        total++; if (v2 !== 1'b1 || f2 !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b/%b want=1/1", v2, f2); end
        cyc(1, 0, 32'h70, 1, 0, 0, 0, 1);
        total++; if (v2 !== 1'b0 || v3 !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b/%b want=0/0", v2, v3); end
        total++; if (f2 !== 1'b0 || id2 !== 2'd0) begin bad++; $display("FAIL flush_ckpt got=%b/%0d want=0/0", f2, id2); end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 32'h99, 1, 0, 0, 0, 0);
        total++; if (d2 !== 32'h99 || id2 !== 2'd1) begin bad++; $display("FAIL mid_pre got=%h/%0d want=99/1", d2, id2); end
        push = 1; din = 32'h55; save = 1;
        #2;
        rst_n = 0;
        #1;
        total++; if (d2 !== 32'h0 || v2 !== 1'b0 || id2 !== 2'd0 || f2 !== 1'b0) begin
            bad++; $display("FAIL mid_reset2 got=%h/%b/%0d/%b want=0/0/0/0", d2, v2, id2, f2);
        end
        total++; if (d3 !== 32'h0 || v3 !== 1'b0 || id3 !== 2'd0 || f3 !== 1'b0) begin
            bad++; $display("FAIL mid_reset3 got=%h/%b/%0d/%b want=0/0/0/0", d3, v3, id3, f3);
        end
        push = 0; din = '0; save = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; flush = 0; push = 0; pop = 0; save = 0; rest = 0; rel = 0;
        din = '0; rid = '0;
        #3;
        test_reset();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        test_basic();
        test_overflow();
        test_pushpop();
        test_restore();
        test_full();
        test_truncate();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
